// File: rtl/gen_trafico_param_if.sv
// Push-side link between the traffic generator and a downstream FIFO.
interface gen_trafico_param_if #(
    parameter int BW = 6
);
    logic          wr;
    logic [BW-1:0] data_out;
    logic          fifo_full;
    logic          fifo_almost_full;

    modport master (
        output wr,
        output data_out,
        input  fifo_full,
        input  fifo_almost_full
    );

    modport slave (
        input  wr,
        input  data_out,
        output fifo_full,
        output fifo_almost_full
    );
endinterface

// File: rtl/gen_trafico_param.sv
// Parameterised burst traffic generator: pushes class-tagged LFSR words into a
// downstream FIFO, honouring full/almost-full back-pressure, with per-class counters.
module gen_trafico_param #(
    parameter  int BW   = 6,
    parameter  int NCH  = 4,
    parameter  int CNTW = 8,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [CW-1:0]        ch_sel,
    input  logic [CNTW-1:0]      num_words,
    input  logic                 use_af,
    output logic                 busy,
    output logic                 done,
    output logic [NCH*CNTW-1:0]  cnt_ch,
    gen_trafico_param_if.master  bus
);
    localparam int PW = BW - CW;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, STALL, DONE} state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [CW-1:0]   ch_q;
    logic [CNTW-1:0] remain;
    logic            use_af_q;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic            block;
    logic            push;
    logic [CW-1:0]   cls_cur;
    logic [CW-1:0]   next_cls;
    logic [CW-1:0]   first_cls;

    // A zero payload is forced to 1 so that no pushed word is ever all-zero.
    function automatic logic [BW-1:0] make_word(input logic [15:0] lf, input logic [CW-1:0] cls);
        logic [PW-1:0] pay;
        pay = lf[PW-1:0];
        if (pay == '0) pay = PW'(1);
        return {cls, pay};
    endfunction

    always_comb begin
        block     = bus.fifo_full | (use_af_q & bus.fifo_almost_full);
        push      = (state == SEND) & ~block;
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        cls_cur   = bus.data_out[BW-1 -: CW];
        first_cls = (mode_q == 2'd2) ? lfsr[15 -: CW] : ch_q;
        unique case (mode_q)
            2'd1:    next_cls = cls_cur + 1'b1;
            2'd2:    next_cls = lfsr_next[15 -: CW];
            default: next_cls = ch_q;
        endcase
    end

    assign bus.wr = push;

    // Datapath updates (push, first-word build) run independently of abort; abort only steers the state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.data_out <= '0;
            cnt_ch       <= '0;
            remain       <= '0;
            lfsr         <= 16'hACE1;
            mode_q       <= '0;
            ch_q         <= '0;
            use_af_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                remain       <= remain - 1'b1;
                lfsr         <= lfsr_next;
                bus.data_out <= make_word(lfsr_next, next_cls);
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (cls_cur == CW'(k) && cnt_ch[k*CNTW +: CNTW] != '1)
                        cnt_ch[k*CNTW +: CNTW] <= cnt_ch[k*CNTW +: CNTW] + 1'b1;
                end
            end
            if (state == LOAD) bus.data_out <= make_word(lfsr, first_cls);

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            mode_q   <= (mode == 2'd3) ? 2'd0 : mode;
                            ch_q     <= ch_sel;
                            remain   <= num_words;
                            use_af_q <= use_af;
                            cnt_ch   <= '0;
                            if (num_words != '0) begin
                                state <= LOAD;
                                busy  <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    LOAD: state <= SEND;
                    SEND: begin
                        if (block) begin
                            state <= STALL;
                        end else if (remain == CNTW'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    STALL: if (!block) state <= SEND;
                    DONE:  state <= IDLE;
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gen_trafico_param.sv
// Bench for gen_trafico_param: burst-level reference model plus directed and random stimulus.
module tb_gen_trafico_param;
    localparam int BW   = 6;
    localparam int NCH  = 4;
    localparam int CNTW = 8;
    localparam int CW   = 2;
    localparam int PW   = BW - CW;

    logic                clk = 1'b0;
    logic                reset_L = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                use_af = 1'b0;
    logic [1:0]          mode = '0;
    logic [CW-1:0]       ch_sel = '0;
    logic [CNTW-1:0]     num_words = '0;
    logic                busy;
    logic                done;
    logic [NCH*CNTW-1:0] cnt_ch;

    gen_trafico_param_if #(.BW(BW)) bus ();

    gen_trafico_param #(.BW(BW), .NCH(NCH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .ch_sel    (ch_sel),
        .num_words (num_words),
        .use_af    (use_af),
        .busy      (busy),
        .done      (done),
        .cnt_ch    (cnt_ch),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is a precomputed list of words; send/stall follows block history.
    logic [15:0]   m_lfsr;
    logic [BW-1:0] m_words[$];
    logic [15:0]   m_lfs[$];
    int            m_k, m_n;
    int            m_phase;    // 0 idle, 1 load, 2 active, 3 done
    bit            m_in_send;
    bit            m_use_af;
    logic [BW-1:0] m_data;
    int            m_cnt[NCH];
    bit            m_blk, m_pushed;
    logic [BW-1:0] seen[$];

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic bit m_block();
        return bus.fifo_full | (m_use_af & bus.fifo_almost_full);
    endfunction

    task automatic plan(input logic [1:0] md, input logic [CW-1:0] ch, input int n);
        logic [15:0]   v;
        logic [PW-1:0] p;
        logic [CW-1:0] c;
        m_words.delete();
        m_lfs.delete();
        v = m_lfsr;
        for (int i = 0; i <= n; i++) begin
            p = v[PW-1:0];
            if (p == 0) p = 1;
            if (md == 2'd2)      c = v[15 -: CW];
            else if (md == 2'd1) c = CW'((int'(ch) + i) % NCH);
            else                 c = ch;
            m_words.push_back({c, p});
            m_lfs.push_back(v);
            v = lstep(v);
        end
    endtask

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_phase   = 0;
            m_lfsr    = 16'hACE1;
            m_data    = '0;
            m_use_af  = 1'b0;
            m_k       = 0;
            m_n       = 0;
            m_in_send = 1'b0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            m_blk    = m_block();
            m_pushed = (m_phase == 2) && m_in_send && !m_blk;
            if (m_pushed) begin
                if (m_cnt[m_words[m_k][BW-1 -: CW]] < (1 << CNTW) - 1)
                    m_cnt[m_words[m_k][BW-1 -: CW]]++;
                m_k++;
                m_data = m_words[m_k];
                m_lfsr = m_lfs[m_k];
            end
            if (m_phase == 1) m_data = m_words[0];
            if (abort) m_phase = 0;
            else case (m_phase)
                0: if (start) begin
                    plan(mode, ch_sel, int'(num_words));
                    m_use_af = use_af;
                    foreach (m_cnt[i]) m_cnt[i] = 0;
                    m_k = 0;
                    m_n = int'(num_words);
                    m_phase = (num_words != 0) ? 1 : 3;
                end
                1: begin m_phase = 2; m_in_send = 1'b1; end
                2: if (m_pushed && m_k == m_n) m_phase = 3;
                   else m_in_send = !m_blk;
                default: m_phase = 0;
            endcase
        end
    end

    logic [NCH*CNTW-1:0] exp_cnt;
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) exp_cnt[k*CNTW +: CNTW] = CNTW'(m_cnt[k]);
        chk("wr", bus.wr, (m_phase == 2) && m_in_send && !m_block());
        chk("data_out", bus.data_out, m_data);
        chk("busy", busy, (m_phase == 1) || (m_phase == 2));
        chk("done", done, m_phase == 3);
        chk("cnt_ch", cnt_ch, exp_cnt);
        if (bus.wr === 1'b1) seen.push_back(bus.data_out);
    end

    task automatic do_reset();
        @(posedge clk); #1 reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
    endtask

    task automatic drive_start(input logic [1:0] md, input logic [CW-1:0] ch,
                               input logic [CNTW-1:0] nw, input logic uaf);
        @(posedge clk); #1;
        mode = md; ch_sel = ch; num_words = nw; use_af = uaf; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk("burst_ends", n < budget, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [BW-1:0] run_a[$];
    logic [BW-1:0] held;

    initial begin
        bus.fifo_full = 1'b0;
        bus.fifo_almost_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_data", bus.data_out, '0);
        chk("reset_cnt", cnt_ch, '0);
        reset_L = 1'b1;

        // Fixed class 3, five words; first LFSR words are 1, 3, 7.
        seen.delete();
        drive_start(2'd0, 2'd3, 8'd5, 1'b0);
        wait_end(50);
        chk("fixed_count", seen.size(), 5);
        chk("fixed_w0", seen[0], 6'h31);
        chk("fixed_w1", seen[1], 6'h33);
        chk("fixed_w2", seen[2], 6'h37);
        foreach (seen[i]) chk("fixed_class", seen[i][BW-1 -: CW], 2'd3);
        chk("fixed_cnt", cnt_ch, 32'h05000000);

        // Round robin from class 2.
        seen.delete();
        drive_start(2'd1, 2'd2, 8'd6, 1'b0);
        wait_end(50);
        chk("rr_count", seen.size(), 6);
        chk("rr_cnt", cnt_ch, 32'h02020101);
        chk("rr_c2", seen[2][BW-1 -: CW], 2'd0);

        // Full held four cycles mid-burst.
        seen.delete();
        drive_start(2'd0, 2'd1, 8'd8, 1'b0);
        repeat (2) @(posedge clk);
        #1 bus.fifo_full = 1'b1;
        held = bus.data_out;
        repeat (4) begin
            @(negedge clk);
            chk("hold_wr", bus.wr, 1'b0);
            chk("hold_data", bus.data_out, held);
        end
        @(posedge clk); #1 bus.fifo_full = 1'b0;
        wait_end(50);
        chk("hold_total", seen.size(), 8);

        // Almost-full throttles only when use_af is latched high.
        seen.delete();
        bus.fifo_almost_full = 1'b1;
        drive_start(2'd0, 2'd0, 8'd3, 1'b1);
        repeat (6) begin @(negedge clk); chk("af_block", bus.wr, 1'b0); end
        @(posedge clk); #1 bus.fifo_almost_full = 1'b0;
        wait_end(50);
        chk("af_total", seen.size(), 3);
        seen.delete();
        bus.fifo_almost_full = 1'b1;
        drive_start(2'd0, 2'd0, 8'd3, 1'b0);
        wait_end(50);
        chk("noaf_total", seen.size(), 3);
        bus.fifo_almost_full = 1'b0;

        // Zero-length burst, then abort mid-SEND.
        seen.delete();
        drive_start(2'd0, 2'd0, 8'd0, 1'b0);
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("zero_done_off", done, 1'b0);
        chk("zero_nowr", seen.size(), 0);
        drive_start(2'd0, 2'd2, 8'd10, 1'b0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_wr", bus.wr, 1'b0);
        repeat (4) begin @(negedge clk); chk("abort_nodone", done, 1'b0); end

        // Longest burst.
        drive_start(2'd3, 2'd0, 8'd255, 1'b0);
        wait_end(300);
        chk("max_cnt", cnt_ch, 32'h000000FF);

        // Reset mid-stall reproduces the post-reset word sequence.
        do_reset();
        seen.delete();
        drive_start(2'd2, 2'd0, 8'd6, 1'b0);
        wait_end(50);
        run_a = seen;
        chk("lfsr_w0", run_a[0], 6'h21);
        do_reset();
        drive_start(2'd2, 2'd0, 8'd6, 1'b0);
        @(posedge clk); @(posedge clk); #1 bus.fifo_full = 1'b1;
        @(posedge clk); #2 reset_L = 1'b0;
        #1;
        chk("async_wr", bus.wr, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_data", bus.data_out, '0);
        chk("async_cnt", cnt_ch, '0);
        @(posedge clk); #1 reset_L = 1'b1;
        bus.fifo_full = 1'b0;
        seen.delete();
        drive_start(2'd2, 2'd0, 8'd6, 1'b0);
        wait_end(50);
        chk("rerun_count", seen.size(), run_a.size());
        foreach (run_a[i]) chk("rerun_word", seen[i], run_a[i]);

        // Random traffic; the per-cycle compare process checks against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start     = ($urandom % 12) == 0;
            abort     = ($urandom % 50) == 0;
            bus.fifo_full        = ($urandom % 4) == 0;
            bus.fifo_almost_full = ($urandom % 3) == 0;
            use_af    = $urandom % 2;
            mode      = 2'($urandom % 4);
            ch_sel    = CW'($urandom % NCH);
            num_words = CNTW'($urandom_range(0, 10));
            if (($urandom % 400) == 0) begin
                reset_L = 1'b0;
                #2 reset_L = 1'b1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        bus.fifo_full = 1'b0; bus.fifo_almost_full = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
